// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 VGA timing constants and helpers
//
// Purpose: timing localparams used as defaults by vga_sync_gen, plus the
// screen limits and refresh line consumed by the pixel generation stage.
// Ports: none (package).

package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int MAX_X     = 640;
  localparam int MAX_Y     = 480;
  localparam int REFR_LINE = 481;

  localparam int CNT_W     = 10;

  typedef logic [CNT_W-1:0] coord_t;

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// rtl/vga_pixel_div.sv - clk-to-pixel-rate divider producing a one-clk tick
//
// Purpose: counts 0..CLK_DIV-1 and asserts p_tick on the last count.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous, active-high reset
//   p_tick  out  one-clk pulse per pixel period (constant 1 when CLK_DIV=1)

module vga_pixel_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_pixel_div: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign p_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA horizontal/vertical timing generator
//
// Purpose: pixel counters, active-low hsync/vsync, video_on and frame_end
// for the pixel generation stage and the VGA pins.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to get a wrapping 8-bit
// frame counter on frame_cnt; otherwise frame_cnt is tied to zero.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   p_tick     out  one-clk pulse per pixel period
//   pixel_x    out  horizontal count, 0..H_TOTAL-1
//   pixel_y    out  vertical count, 0..V_TOTAL-1
//   video_on   out  high inside the visible area
//   hsync      out  active-low horizontal sync
//   vsync      out  active-low vertical sync
//   frame_end  out  one-clk pulse on the last pixel tick of a frame
//   frame_cnt  out  frame counter (zero unless VGA_SYNC_FRAME_CNT_EN)

module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit in 10-bit counters");
  end

  logic   w_p_tick;
  coord_t r_h_cnt;
  coord_t r_v_cnt;
  coord_t w_h_next;
  coord_t w_v_next;
  logic   w_h_wrap;
  logic   r_hsync;
  logic   r_vsync;

  vga_pixel_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .p_tick (w_p_tick)
  );

  assign w_h_wrap = (r_h_cnt == H_LAST);

  always_comb begin
    w_h_next = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end
  end

  // Sync registers are computed from the next counter values so that they
  // change on the same clk as pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_p_tick) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
      r_hsync <= ~in_window(w_h_next, HS_START, HS_END);
      r_vsync <= ~in_window(w_v_next, VS_START, VS_END);
    end
  end

  assign p_tick    = w_p_tick;
  assign pixel_x   = r_h_cnt;
  assign pixel_y   = r_v_cnt;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = (int'(r_h_cnt) < H_DISPLAY) && (int'(r_v_cnt) < V_DISPLAY);
  // Gated by rst so a reset landing on the last pixel never reports a frame.
  assign frame_end = ~rst & w_p_tick & w_h_wrap & (r_v_cnt == V_LAST);

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (frame_end) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen

module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VGA_SYNC_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Full-size 640x480 instance, CLK_DIV=2.
  logic       rst_a;
  logic       a_tick, a_von, a_hs, a_vs, a_fe;
  logic [9:0] a_px, a_py;
  logic [7:0] a_fc;

  vga_sync_gen u_dut (
    .clk       (clk),
    .rst       (rst_a),
    .p_tick    (a_tick),
    .pixel_x   (a_px),
    .pixel_y   (a_py),
    .video_on  (a_von),
    .hsync     (a_hs),
    .vsync     (a_vs),
    .frame_end (a_fe),
    .frame_cnt (a_fc)
  );

  // Miniature instance (8x6 total, CLK_DIV=1) for frame-level behaviour.
  // hsync low for x in [5,6], vsync low for y == 4, visible x<4 && y<3.
  logic       rst_b;
  logic       b_tick, b_von, b_hs, b_vs, b_fe;
  logic [9:0] b_px, b_py;
  logic [7:0] b_fc;

  vga_sync_gen #(
    .CLK_DIV   (1),
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) u_small (
    .clk       (clk),
    .rst       (rst_b),
    .p_tick    (b_tick),
    .pixel_x   (b_px),
    .pixel_y   (b_py),
    .video_on  (b_von),
    .hsync     (b_hs),
    .vsync     (b_vs),
    .frame_end (b_fe),
    .frame_cnt (b_fc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int         k;
    logic [9:0] px;
    logic [9:0] py;
    logic       pt;
    logic       von;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int now;
    int low_cnt, first_low, von_bad, hs_bad;
    int bad, fe_cnt, fe_pos, vs_low, kk;

    // k = clks since reset release on the full-size instance.
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{2,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1279, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1280, 10'd640, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1503, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1504, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1599, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1600, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1601, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);

    chk("a_reset_frame_end", a_fe, 0);
    chk("a_reset_frame_cnt", a_fc, 0);
    rst_a = 1'b0;
    now = 0;

    for (int i = 0; i < 13; i++) begin
      while (now < tbl[i].k) begin
        @(negedge clk);
        now++;
      end
      chk($sformatf("k%0d_pixel_x", tbl[i].k),  a_px,   tbl[i].px);
      chk($sformatf("k%0d_pixel_y", tbl[i].k),  a_py,   tbl[i].py);
      chk($sformatf("k%0d_p_tick", tbl[i].k),   a_tick, tbl[i].pt);
      chk($sformatf("k%0d_video_on", tbl[i].k), a_von,  tbl[i].von);
      chk($sformatf("k%0d_hsync", tbl[i].k),    a_hs,   tbl[i].hs);
      chk($sformatf("k%0d_vsync", tbl[i].k),    a_vs,   tbl[i].vs);
    end

    // Sweep line 1 once per pixel tick: hsync pulse width and start,
    // video_on and hsync against a per-pixel model.
    low_cnt = 0; first_low = -1; von_bad = 0; hs_bad = 0;
    while (now < 3200) begin
      if (a_tick) begin
        if (!a_hs) begin
          low_cnt++;
          if (first_low < 0) first_low = a_px;
        end
        if (a_von != (a_px < 640 && a_py < 480)) von_bad++;
        if (a_hs != !(a_px >= 656 && a_px <= 751)) hs_bad++;
      end
      @(negedge clk);
      now++;
    end
    chk("line_hsync_low_ticks", low_cnt, 96);
    chk("line_hsync_first_x", first_low, 656);
    chk("line_video_on_model_errs", von_bad, 0);
    chk("line_hsync_model_errs", hs_bad, 0);
    chk("line2_start_y", a_py, 2);

    // Mid-line reset at x=700 of line 2 while hsync is low.
    while (now < 4600) begin
      @(negedge clk);
      now++;
    end
    chk("a_pre_rst_x", a_px, 700);
    chk("a_pre_rst_hsync", a_hs, 0);
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_rst_x", a_px, 0);
    chk("a_rst_y", a_py, 0);
    chk("a_rst_hsync", a_hs, 1);
    chk("a_rst_vsync", a_vs, 1);
    chk("a_rst_p_tick", a_tick, 0);
    chk("a_rst_frame_end", a_fe, 0);
    rst_a = 1'b0;

    // Miniature instance: one full frame, k = 0..47, 48 clks per frame.
    chk("b_reset_frame_cnt", b_fc, 0);
    rst_b = 1'b0;
    bad = 0; fe_cnt = 0; fe_pos = -1; vs_low = 0;
    for (int k = 0; k < 48; k++) begin
      if (b_px != k % 8 || b_py != k / 8) bad++;
      if (b_tick != 1'b1) bad++;
      if (b_von != ((k % 8) < 4 && (k / 8) < 3)) bad++;
      if (b_hs != !((k % 8) == 5 || (k % 8) == 6)) bad++;
      if (b_vs != ((k / 8) != 4)) bad++;
      if (!b_vs) vs_low++;
      if (b_fe) begin
        fe_cnt++;
        fe_pos = k;
      end
      @(negedge clk);
    end
    chk("b_frame_model_errs", bad, 0);
    chk("b_frame_end_count", fe_cnt, 1);
    chk("b_frame_end_pos", fe_pos, 47);
    chk("b_vsync_low_pixels", vs_low, 8);
    chk("b_wrap_x", b_px, 0);
    chk("b_wrap_y", b_py, 0);
    chk("b_frame_cnt_1", b_fc, FC_EN ? 1 : 0);

    // Mid-frame reset at (5,4): hsync and vsync both low.
    repeat (37) @(negedge clk);
    chk("b_pre_rst_x", b_px, 5);
    chk("b_pre_rst_y", b_py, 4);
    chk("b_pre_rst_hsync", b_hs, 0);
    chk("b_pre_rst_vsync", b_vs, 0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_rst_x", b_px, 0);
    chk("b_rst_y", b_py, 0);
    chk("b_rst_hsync", b_hs, 1);
    chk("b_rst_vsync", b_vs, 1);
    chk("b_rst_frame_cnt", b_fc, 0);
    rst_b = 1'b0;

    // Reset arriving exactly on the last pixel must suppress frame_end.
    repeat (47) @(negedge clk);
    chk("b_last_pixel_frame_end", b_fe, 1);
    rst_b = 1'b1;
    #1;
    chk("b_frame_end_during_rst", b_fe, 0);
    @(negedge clk);
    chk("b_after_rst_frame_cnt", b_fc, 0);
    chk("b_after_rst_y", b_py, 0);
    rst_b = 1'b0;

    // Frame counter: 3 frames, then 255, then wrap at 256.
    repeat (3 * 48) @(negedge clk);
    chk("b_frame_cnt_3", b_fc, FC_EN ? 3 : 0);
    kk = 0;
    for (int f = 3; f < 255; f++) begin
      repeat (48) @(negedge clk);
      if (b_fc != (FC_EN ? f + 1 : 0)) kk++;
    end
    chk("b_frame_cnt_sweep_errs", kk, 0);
    chk("b_frame_cnt_255", b_fc, FC_EN ? 255 : 0);
    repeat (48) @(negedge clk);
    chk("b_frame_cnt_wrap", b_fc, 0);
    chk("a_frame_cnt_idle", a_fc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing: pixel-rate tick, horizontal/vertical counters, active-low hsync/vsync and video_on.
- Sits directly upstream of the pixel generation stage. Drives its pixel_x, pixel_y and video_on inputs.
- Sits upstream of the VGA pins for hsync/vsync.
- Single clock domain (clk). Pixel rate is derived by an internal divider, not by a second clock.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal range >=1
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- p_tick  out  1  one-clk pulse per pixel period
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high when (pixel_x,pixel_y) is in the visible area
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_end  out  1  one-clk pulse on the last pixel tick of a frame
- frame_cnt  out  8  frame counter (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high, on clk (already decided).
- Derived totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Reset values (applied on any rst cycle, including mid-line or mid-frame; no partial state survives):
  - div_cnt=0, h_cnt=0, v_cnt=0
  - hsync=1, vsync=1, p_tick=0, frame_cnt=0
  - frame_end is 0 while rst is asserted; after reset it depends only on the counters and p_tick.
  - Consequence: video_on=1 immediately after reset, because (0,0) is visible.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt==CLK_DIV-1), combinational from the register.
  - With CLK_DIV=1, p_tick is constantly 1 after reset.
- Counters:
  - Advance only on clk edges where p_tick=1.
  - h_cnt: increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt: increments only on an h_cnt wrap; at V_TOTAL-1 it wraps to 0.
  - Both counters update in the same clk.
- Outputs:
  - pixel_x = h_cnt and pixel_y = v_cnt, direct register outputs, 0 latency.
  - video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY), combinational from the registers.
  - Counter values are always well-defined with no over-range.
- Sync:
  - hsync and vsync are registers, updated on p_tick edges from the next counter values, so they are cycle-aligned with pixel_x and pixel_y.
  - hsync=0 iff h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751].
  - vsync=0 iff v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491].
- frame_end = p_tick && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
  - On the next clk the counters read (0,0).
- Width rules:
  - Counters are 10 bits.
  - Elaboration check: H_TOTAL <= 1024 and V_TOTAL <= 1024.
  - div_cnt width is $clog2(CLK_DIV), with a minimum of 1.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - frame_cnt is an 8-bit register, incremented on every frame_end.
  - It wraps 255->0 and resets to 0.
  - Intended for animation pacing and blinking downstream.
- Undefined:
  - frame_cnt is tied to 8'd0 and no register is inferred.
  - The port remains present, so instantiations are unchanged.

Decomposition:
- Shared package vga_pkg holds:
  - the timing localparams (H_DISPLAY..V_BACK, H_TOTAL, V_TOTAL)
  - MAX_X=640, MAX_Y=480
  - REFR_LINE=481, used by pixel generation for its refresh tick
- One natural sub-module: vga_pixel_div, the CLK_DIV divider producing p_tick. The counters and sync logic stay in the top module.

Test Plan:
- Tick spacing: CLK_DIV=2, release rst -> p_tick=0,1,0,1...; pixel_x steps 0->1 after 2 clks; video_on=1 at reset release.
- Line timing: run one line -> h_cnt wraps 799->0 after 1600 clks; hsync low exactly 96 pixel ticks, starting when pixel_x=656.
- Frame timing: run to v_cnt=490 -> vsync low for 2 lines; video_on=0 for any pixel_x>=640 or pixel_y>=480.
- Frame end: single frame_end pulse at (799,524), 840000 clks after reset; next clk reads (0,0). Also check the refresh point (pixel_y=481, pixel_x=0) is reached once per frame.
- Reset mid-operation: assert rst at (700,490), with hsync and vsync both low -> next clk counters=(0,0), hsync=vsync=1, p_tick=0.
- With VGA_SYNC_FRAME_CNT_EN: 3 frames -> frame_cnt=3; force 256 frames -> wraps to 0. Without the macro: frame_cnt stays 0 throughout.
